// File: rtl/fifobram_v2.sv
// fifobram_v2: addressed BRAM plus an independent circular FIFO sharing
// one registered read port, with occupancy status and sticky error flags.
//
// Parameters:
//   WIDTH             data width (>= 1)
//   LOG2_DEPTH        log2 of entries per store (>= 2)
//   ALMOSTFULL_MARGIN free-slot threshold for almostfull (1..DEPTH-1)
//   READ_LATENCY      cycles from accepted read to rvalid (1 or 2)
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   we, waddr, wdata  write strobe, BRAM write address, write data
//   wfifobram         write target: 00 none, 01 BRAM, 10 FIFO, 11 both
//   re, raddr         read strobe, BRAM read address
//   rfifobram         read source: 01 BRAM, 10 FIFO, 00/11 illegal
//   rdata, rvalid     read data and its one-cycle qualifier
//   count             FIFO occupancy 0..DEPTH
//   almostfull, empty registered FIFO status
//   err_clear         clears the sticky error flags
//   overflow, underflow, illegal_read  sticky error flags
//
// Build option: define FIFOBRAM_ERROR_FLAGS_EN to build the error flags.
// Without it the three flags are tied low and err_clear is ignored.

module fifobram_v2 #(
    parameter int WIDTH             = 32,
    parameter int LOG2_DEPTH        = 5,
    parameter int ALMOSTFULL_MARGIN = 4,
    parameter int READ_LATENCY      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [LOG2_DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [1:0]            wfifobram,
    input  logic                  re,
    input  logic [LOG2_DEPTH-1:0] raddr,
    input  logic [1:0]            rfifobram,
    output logic [WIDTH-1:0]      rdata,
    output logic                  rvalid,
    output logic [LOG2_DEPTH:0]   count,
    output logic                  almostfull,
    output logic                  empty,
    input  logic                  err_clear,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  illegal_read
);

    localparam int DEPTH    = 1 << LOG2_DEPTH;
    localparam int AF_LEVEL = DEPTH - ALMOSTFULL_MARGIN;

    typedef logic [LOG2_DEPTH-1:0] ptr_t;
    typedef logic [LOG2_DEPTH:0]   cnt_t;

    // Elaboration-time parameter checks
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("fifobram_v2: READ_LATENCY must be 1 or 2");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("fifobram_v2: WIDTH must be >= 1");
    end
    if (LOG2_DEPTH < 2) begin : g_bad_depth
        $error("fifobram_v2: LOG2_DEPTH must be >= 2");
    end
    if (ALMOSTFULL_MARGIN < 1 || ALMOSTFULL_MARGIN > DEPTH - 1) begin : g_bad_margin
        $error("fifobram_v2: ALMOSTFULL_MARGIN out of range");
    end

    // Storage
    logic [WIDTH-1:0] bram_mem [DEPTH];
    logic [WIDTH-1:0] fifo_mem [DEPTH];

    ptr_t wptr;
    ptr_t rptr;
    cnt_t count_nxt;

    // Request decode
    logic push_req;
    logic pop_req;
    logic bram_rd;
    logic pop_ok;
    logic push_ok;
    logic rd_ok;
    logic full;

    assign full     = (count == cnt_t'(DEPTH));
    assign push_req = we & wfifobram[1];
    assign pop_req  = re & (rfifobram == 2'b10);
    assign bram_rd  = re & (rfifobram == 2'b01);

    // A pop needs data already stored: a same-cycle push cannot satisfy it.
    assign pop_ok  = pop_req & ~empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign push_ok = push_req & (~full | pop_ok);
    assign rd_ok   = bram_rd | pop_ok;

    // Memory writes; BRAM contents survive reset.
    always_ff @(posedge clk) begin
        if (we && wfifobram[0]) begin
            bram_mem[waddr] <= wdata;
        end
        if (push_ok) begin
            fifo_mem[wptr] <= wdata;
        end
    end

    // Read word sampled at the same edge as any write: old data wins.
    logic [WIDTH-1:0] rd_word;
    assign rd_word = bram_rd ? bram_mem[raddr] : fifo_mem[rptr];

    // Occupancy bookkeeping
    always_comb begin
        count_nxt = count;
        unique case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + cnt_t'(1);
            2'b01:   count_nxt = count - cnt_t'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            empty      <= 1'b1;
            almostfull <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + ptr_t'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + ptr_t'(1);
            end
            count      <= count_nxt;
            empty      <= (count_nxt == '0);
            almostfull <= (count_nxt >= cnt_t'(AF_LEVEL));
        end
    end

    // Read pipeline: fin_* feeds the output register, either directly
    // from the memory (latency 1) or via one extra stage (latency 2).
    logic             fin_valid;
    logic [WIDTH-1:0] fin_data;

    if (READ_LATENCY == 2) begin : g_lat2
        logic             s1_valid;
        logic [WIDTH-1:0] s1_data;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_valid <= 1'b0;
            end else begin
                s1_valid <= rd_ok;
            end
        end

        always_ff @(posedge clk) begin
            if (rd_ok) begin
                s1_data <= rd_word;
            end
        end

        assign fin_valid = s1_valid;
        assign fin_data  = s1_data;
    end else begin : g_lat1
        assign fin_valid = rd_ok;
        assign fin_data  = rd_word;
    end

    // rdata holds its last value whenever no new word arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= fin_valid;
            if (fin_valid) begin
                rdata <= fin_data;
            end
        end
    end

`ifdef FIFOBRAM_ERROR_FLAGS_EN
    logic ovf_evt;
    logic unf_evt;
    logic bad_rd;

    assign ovf_evt = push_req & ~push_ok;
    assign unf_evt = pop_req & ~pop_ok;
    assign bad_rd  = re & (rfifobram[1] ~^ rfifobram[0]);

    // A new event outranks a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            illegal_read <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (err_clear) begin
                overflow <= 1'b0;
            end
            if (unf_evt) begin
                underflow <= 1'b1;
            end else if (err_clear) begin
                underflow <= 1'b0;
            end
            if (bad_rd) begin
                illegal_read <= 1'b1;
            end else if (err_clear) begin
                illegal_read <= 1'b0;
            end
        end
    end
`else
    logic unused_err_clear;
    assign unused_err_clear = err_clear;

    assign overflow     = 1'b0;
    assign underflow    = 1'b0;
    assign illegal_read = 1'b0;
`endif

endmodule

// File: tb/tb_fifobram_v2.sv
// Testbench for fifobram_v2: two instances (read latency 1 and 2) share
// stimulus and are checked against a queue-based reference model.
`timescale 1ns/1ps

module tb_fifobram_v2;

    localparam int W     = 32;
    localparam int LD    = 3;
    localparam int DEPTH = 8;
    localparam int AM    = 2;
`ifdef FIFOBRAM_ERROR_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          we;
    logic [LD-1:0] waddr;
    logic [W-1:0]  wdata;
    logic [1:0]    wfb;
    logic          re;
    logic [LD-1:0] raddr;
    logic [1:0]    rfb;
    logic          errc;

    logic [W-1:0]  rdata1, rdata2;
    logic          rvalid1, rvalid2;
    logic [LD:0]   count1, count2;
    logic          af1, af2, empty1, empty2;
    logic          ov1, un1, il1, ov2, un2, il2;

    always #5 clk = ~clk;

    fifobram_v2 #(
        .WIDTH(W), .LOG2_DEPTH(LD), .ALMOSTFULL_MARGIN(AM), .READ_LATENCY(1)
    ) u1 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .wfifobram(wfb), .re(re), .raddr(raddr), .rfifobram(rfb),
        .rdata(rdata1), .rvalid(rvalid1), .count(count1),
        .almostfull(af1), .empty(empty1), .err_clear(errc),
        .overflow(ov1), .underflow(un1), .illegal_read(il1)
    );

    fifobram_v2 #(
        .WIDTH(W), .LOG2_DEPTH(LD), .ALMOSTFULL_MARGIN(AM), .READ_LATENCY(2)
    ) u2 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .wfifobram(wfb), .re(re), .raddr(raddr), .rfifobram(rfb),
        .rdata(rdata2), .rvalid(rvalid2), .count(count2),
        .almostfull(af2), .empty(empty2), .err_clear(errc),
        .overflow(ov2), .underflow(un2), .illegal_read(il2)
    );

    int passed = 0;
    int total  = 0;

    // Reference model state
    logic [W-1:0] m_bram [DEPTH];
    logic [W-1:0] m_q [$];
    bit           m_ov, m_un, m_il;
    bit           pv;
    logic [W-1:0] pd;
    bit           exp_v1, exp_v2;
    logic [W-1:0] exp_d1, exp_d2;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ov = 0; m_un = 0; m_il = 0;
        pv = 0; pd = '0;
        exp_v1 = 0; exp_v2 = 0;
        exp_d1 = '0; exp_d2 = '0;
    endtask

    task automatic model_step();
        int           pre;
        bit           popped, ev, s_ov, s_un, s_il;
        logic [W-1:0] evd;
        pre = m_q.size();
        popped = 0; ev = 0; evd = '0;
        s_ov = 0; s_un = 0; s_il = 0;
        if (re) begin
            if (rfb == 2'b01) begin
                ev = 1; evd = m_bram[raddr];
            end else if (rfb == 2'b10) begin
                if (pre > 0) begin
                    ev = 1; evd = m_q.pop_front(); popped = 1;
                end else begin
                    s_un = 1;
                end
            end else begin
                s_il = 1;
            end
        end
        if (we && wfb[0]) m_bram[waddr] = wdata;
        if (we && wfb[1]) begin
            if (pre < DEPTH || popped) m_q.push_back(wdata);
            else s_ov = 1;
        end
        if (FLAGS) begin
            m_ov = s_ov ? 1'b1 : (errc ? 1'b0 : m_ov);
            m_un = s_un ? 1'b1 : (errc ? 1'b0 : m_un);
            m_il = s_il ? 1'b1 : (errc ? 1'b0 : m_il);
        end
        exp_v2 = pv;
        if (pv) exp_d2 = pd;
        pv = ev; pd = evd;
        exp_v1 = ev;
        if (ev) exp_d1 = evd;
    endtask

    task automatic check_all();
        int n;
        n = m_q.size();
        chk("count1", 64'(count1), 64'(n));
        chk("count2", 64'(count2), 64'(n));
        chk("empty1", 64'(empty1), 64'(n == 0));
        chk("empty2", 64'(empty2), 64'(n == 0));
        chk("almostfull1", 64'(af1), 64'(n >= DEPTH - AM));
        chk("almostfull2", 64'(af2), 64'(n >= DEPTH - AM));
        chk("overflow1", 64'(ov1), 64'(m_ov));
        chk("underflow1", 64'(un1), 64'(m_un));
        chk("illegal1", 64'(il1), 64'(m_il));
        chk("overflow2", 64'(ov2), 64'(m_ov));
        chk("underflow2", 64'(un2), 64'(m_un));
        chk("illegal2", 64'(il2), 64'(m_il));
        chk("rvalid1", 64'(rvalid1), 64'(exp_v1));
        chk("rvalid2", 64'(rvalid2), 64'(exp_v2));
        chk("rdata1", 64'(rdata1), 64'(exp_d1));
        chk("rdata2", 64'(rdata2), 64'(exp_d2));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic i_we, input logic [1:0] i_wfb,
                         input int i_waddr, input logic [W-1:0] i_wdata,
                         input logic i_re, input logic [1:0] i_rfb,
                         input int i_raddr, input logic i_errc);
        we = i_we; wfb = i_wfb; waddr = LD'(i_waddr); wdata = i_wdata;
        re = i_re; rfb = i_rfb; raddr = LD'(i_raddr); errc = i_errc;
        tick();
    endtask

    task automatic idle();
        we = 0; wfb = 2'b00; waddr = '0; wdata = '0;
        re = 0; rfb = 2'b00; raddr = '0; errc = 0;
    endtask

    task automatic do_reset();
        idle();
        #1 reset = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        logic       we;
        logic [1:0] wfb;
        logic [W-1:0] wdata;
        logic       re;
        logic [1:0] rfb;
        int         e_count;
        logic       e_af;
        logic       e_empty;
        logic       e_rv1;
        logic [W-1:0] e_rd1;
        logic       e_ov;
    } vec_t;

    vec_t tbl [17];

    initial begin
        // Push 9 words into a depth-8 FIFO, then drain it.
        for (int i = 0; i < 9; i++) begin
            tbl[i].we = 1; tbl[i].wfb = 2'b10; tbl[i].wdata = W'(32'h10 + i);
            tbl[i].re = 0; tbl[i].rfb = 2'b00;
            tbl[i].e_count = (i < 8) ? i + 1 : 8;
            tbl[i].e_af = (tbl[i].e_count >= 6);
            tbl[i].e_empty = 0;
            tbl[i].e_rv1 = 0; tbl[i].e_rd1 = '0;
            tbl[i].e_ov = FLAGS && (i == 8);
        end
        for (int j = 0; j < 8; j++) begin
            tbl[9+j].we = 0; tbl[9+j].wfb = 2'b00; tbl[9+j].wdata = '0;
            tbl[9+j].re = 1; tbl[9+j].rfb = 2'b10;
            tbl[9+j].e_count = 7 - j;
            tbl[9+j].e_af = ((7 - j) >= 6);
            tbl[9+j].e_empty = (j == 7);
            tbl[9+j].e_rv1 = 1; tbl[9+j].e_rd1 = W'(32'h10 + j);
            tbl[9+j].e_ov = FLAGS;
        end

        idle();
        model_reset();
        #1 reset = 1'b1;
        #2;
        check_all();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // Give every BRAM word a known value.
        for (int a = 0; a < DEPTH; a++) begin
            drive(1, 2'b01, a, W'(32'hB000 + a), 0, 2'b00, 0, 0);
        end

        // Fill / overflow / drain table
        for (int k = 0; k < 17; k++) begin
            drive(tbl[k].we, tbl[k].wfb, 0, tbl[k].wdata,
                  tbl[k].re, tbl[k].rfb, 0, 0);
            chk("tbl_count", 64'(count1), 64'(tbl[k].e_count));
            chk("tbl_af", 64'(af1), 64'(tbl[k].e_af));
            chk("tbl_empty", 64'(empty1), 64'(tbl[k].e_empty));
            chk("tbl_overflow", 64'(ov1), 64'(tbl[k].e_ov));
            chk("tbl_rvalid", 64'(rvalid1), 64'(tbl[k].e_rv1));
            if (tbl[k].e_rv1) chk("tbl_rdata", 64'(rdata1), 64'(tbl[k].e_rd1));
        end
        drive(0, 2'b00, 0, 0, 0, 2'b00, 0, 1);
        chk("clear_overflow", 64'(ov1), 64'd0);

        // Latency-2 BRAM read and read-first collision
        drive(1, 2'b01, 3, 32'hA5A5A5A5, 0, 2'b00, 0, 0);
        drive(0, 2'b00, 0, 0, 1, 2'b01, 3, 0);
        chk("lat2_early", 64'(rvalid2), 64'd0);
        drive(0, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        chk("lat2_rvalid", 64'(rvalid2), 64'd1);
        chk("lat2_rdata", 64'(rdata2), 64'hA5A5A5A5);
        drive(0, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        chk("lat2_pulse", 64'(rvalid2), 64'd0);
        chk("lat2_hold", 64'(rdata2), 64'hA5A5A5A5);
        drive(1, 2'b01, 5, 32'h1, 0, 2'b00, 0, 0);
        drive(1, 2'b01, 5, 32'h2, 1, 2'b01, 5, 0);
        chk("rf_lat1", 64'(rdata1), 64'h1);
        drive(0, 2'b00, 0, 0, 1, 2'b01, 5, 0);
        chk("rf_lat2", 64'(rdata2), 64'h1);
        chk("rf_new", 64'(rdata1), 64'h2);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) drive(1, 2'b10, 0, W'(32'h20 + i), 0, 2'b00, 0, 0);
        drive(1, 2'b10, 0, 32'h99, 1, 2'b10, 0, 0);
        chk("full_pp_data", 64'(rdata1), 64'h20);
        chk("full_pp_count", 64'(count1), 64'd8);
        chk("full_pp_ovf", 64'(ov1), 64'd0);
        for (int i = 0; i < 8; i++) drive(0, 2'b00, 0, 0, 1, 2'b10, 0, 0);
        chk("full_pp_last", 64'(rdata1), 64'h99);
        chk("full_pp_empty", 64'(empty1), 64'd1);

        // Pop on empty with simultaneous push
        drive(1, 2'b10, 0, 32'h42, 1, 2'b10, 0, 0);
        chk("ep_rvalid", 64'(rvalid1), 64'd0);
        chk("ep_underflow", 64'(un1), 64'(FLAGS));
        chk("ep_count", 64'(count1), 64'd1);
        drive(0, 2'b00, 0, 0, 1, 2'b10, 0, 0);
        chk("ep_pop", 64'(rdata1), 64'h42);
        drive(0, 2'b00, 0, 0, 0, 2'b00, 0, 1);
        chk("ep_clear", 64'(un1), 64'd0);

        // Write both targets, then an illegal read
        drive(1, 2'b11, 2, 32'h77, 0, 2'b00, 0, 0);
        drive(0, 2'b00, 0, 0, 1, 2'b01, 2, 0);
        chk("both_bram", 64'(rdata1), 64'h77);
        drive(0, 2'b00, 0, 0, 1, 2'b10, 0, 0);
        chk("both_fifo", 64'(rdata1), 64'h77);
        drive(0, 2'b00, 0, 0, 1, 2'b11, 0, 0);
        chk("illegal_rvalid", 64'(rvalid1), 64'd0);
        chk("illegal_flag", 64'(il1), 64'(FLAGS));

        // Reset with reads in flight
        drive(1, 2'b10, 0, 32'h55, 0, 2'b00, 0, 0);
        drive(0, 2'b00, 0, 0, 1, 2'b01, 3, 0);
        drive(0, 2'b00, 0, 0, 1, 2'b01, 5, 0);
        do_reset();
        chk("rst_count", 64'(count2), 64'd0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 2'b00, 0, 0, 0, 2'b00, 0, 0);
            chk("rst_no_rvalid", 64'(rvalid2), 64'd0);
        end

        // Randomized traffic in push-heavy and pop-heavy phases
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 299) == 0) begin
                    do_reset();
                end
                we = ($urandom_range(0, 99) < ((p % 2 == 0) ? 75 : 35));
                wfb = 2'($urandom_range(0, 3));
                waddr = LD'($urandom_range(0, DEPTH - 1));
                wdata = W'($urandom);
                re = ($urandom_range(0, 99) < ((p % 2 == 0) ? 35 : 75));
                if ($urandom_range(0, 19) == 0) rfb = $urandom_range(0, 1) ? 2'b11 : 2'b00;
                else rfb = $urandom_range(0, 1) ? 2'b10 : 2'b01;
                raddr = LD'($urandom_range(0, DEPTH - 1));
                errc = ($urandom_range(0, 24) == 0);
                tick();
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifobram_v2.md
FIFOBRAM_V2 -- requirements
Module: fifobram_v2

Interface
REQ-001 WIDTH, default 32: data width in bits; SHALL be >= 1.
REQ-002 LOG2_DEPTH, default 5: log2 of entries per store (DEPTH = 2**LOG2_DEPTH); SHALL be >= 2.
REQ-003 ALMOSTFULL_MARGIN, default 4: free-slot threshold for almostfull; SHALL be in 1..DEPTH-1.
REQ-004 READ_LATENCY, default 1: cycles from accepted read to rvalid; SHALL be 1 or 2, any other value a compile-time error.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 we  in  1  write strobe.
REQ-008 waddr  in  LOG2_DEPTH  BRAM write address.
REQ-009 wdata  in  WIDTH  write data.
REQ-010 wfifobram  in  2  write target: 00 none, 01 BRAM, 10 FIFO, 11 both.
REQ-011 re  in  1  read strobe.
REQ-012 raddr  in  LOG2_DEPTH  BRAM read address.
REQ-013 rfifobram  in  2  read source: 01 BRAM, 10 FIFO; 00/11 illegal.
REQ-014 rdata  out  WIDTH  read data, valid with rvalid.
REQ-015 rvalid  out  1  one-cycle read-data qualifier.
REQ-016 count  out  LOG2_DEPTH+1  FIFO occupancy 0..DEPTH.
REQ-017 almostfull  out  1  count >= DEPTH-ALMOSTFULL_MARGIN.
REQ-018 empty  out  1  count == 0.
REQ-019 err_clear  in  1  clears sticky error flags.
REQ-020 overflow, underflow, illegal_read  out  1 each  sticky error flags.

Function
REQ-021 Block SHALL hold two independent DEPTH x WIDTH stores: addressed BRAM and circular FIFO.
REQ-022 we=1, wfifobram=01 SHALL write wdata to BRAM[waddr]; 10 SHALL push to FIFO; 11 SHALL do both in the same cycle; 00 SHALL write nothing.
REQ-023 re=1, rfifobram=01 SHALL read BRAM[raddr]; 10 SHALL pop FIFO head; 00/11 SHALL be ignored (no rvalid) and set illegal_read.
REQ-024 Accepted read SHALL produce rvalid=1 with rdata exactly READ_LATENCY cycles later; reads SHALL be fully pipelined, one per cycle.
REQ-025 rdata SHALL hold its last value while rvalid=0.
REQ-026 BRAM read and write to the same address in one cycle SHALL return old data (read-first).
REQ-027 FIFO push SHALL be accepted iff count < DEPTH or a FIFO pop is accepted in the same cycle; rejected push SHALL be dropped and set overflow.
REQ-028 FIFO pop SHALL be accepted iff count > 0; rejected pop SHALL produce no rvalid and set underflow; a same-cycle push to an empty FIFO SHALL NOT satisfy the pop.
REQ-029 Simultaneous accepted push and pop SHALL leave count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-030 count, almostfull, empty SHALL be registered and reflect the cycle's accepted push/pop on the next edge.
REQ-031 Error flags SHALL be sticky until err_clear=1; a same-cycle error event SHALL take priority over err_clear.

Reset
REQ-032 Asserting reset SHALL immediately clear: FIFO pointers, count=0, empty=1, almostfull=0, rvalid=0 and all read-pipeline valid bits, rdata=0, all error flags=0.
REQ-033 BRAM contents SHALL NOT be reset; FIFO contents are don't-care after reset.
REQ-034 Reads in flight when reset asserts SHALL be discarded, no rvalid after deassertion.

Configuration
REQ-035 With FIFOBRAM_ERROR_FLAGS_EN defined, overflow, underflow, illegal_read SHALL behave per REQ-023/027/028/031.
REQ-036 Without FIFOBRAM_ERROR_FLAGS_EN, those three outputs SHALL be tied 0, err_clear ignored, and no error logic synthesised; all other behaviour identical.

Verification (WIDTH=32, LOG2_DEPTH=3, ALMOSTFULL_MARGIN=2, macro defined unless stated)
REQ-037 Push 0x10..0x17 (8 words) -> count 1..8, almostfull rises when count=6, 9th push 0x18 dropped with overflow=1; 8 pops return 0x10..0x17 in order, empty=1.
REQ-038 READ_LATENCY=2: write BRAM[3]=0xA5A5A5A5, read raddr=3 next cycle -> rvalid pulse exactly 2 cycles after re with 0xA5A5A5A5; same-cycle read/write BRAM[5] old 0x1 new 0x2 -> returns 0x1.
REQ-039 FIFO full (count=8) with simultaneous push 0x99 and pop -> pop returns oldest word, count stays 8, overflow stays 0, 0x99 later emerges last.
REQ-040 Pop on empty with simultaneous push 0x42 -> no rvalid, underflow=1, count=1; next pop returns 0x42; err_clear -> underflow=0.
REQ-041 wfifobram=11, wdata=0x77, waddr=2 -> BRAM[2]=0x77 and FIFO head 0x77; rfifobram=11 read -> no rvalid, illegal_read=1.
REQ-042 Reset asserted mid-stream with 2 reads in flight (READ_LATENCY=2) -> outputs reset asynchronously, no rvalid after release, count=0; macro undefined run of REQ-037 -> overflow stays 0.
